dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the 32-byte, byte-addressed data memory (4-byte little-endian word access).
- Port 0 is the core load/store stage; port 1 is a debug/DMA loader.
- Grants one word access at a time with round-robin fairness, drives the memory read/write strobes for exactly one cycle, and returns registered read data plus an error flag for misaligned or out-of-range addresses.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 17 +
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory size, address check.
// Pure declarations; no timing or flow-control behaviour of its own.
// Used by dmem_arbiter and its bench-visible parameters.
package dmem_pkg;

    localparam int MEM_BYTES = 32;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Word-aligned and fully inside memory; unsigned compare so 0xFFFFFFFC cannot wrap in.
    function automatic logic addr_legal(input logic [31:0] addr, input int mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the port that did not win last.
// Combinational, zero latency; the last-winner register lives in the parent.
// No backpressure: an empty req vector yields an empty grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-word access sequencer for the byte-addressed data memory.
// Latency: request sampled in IDLE at edge N, gnt + strobe in cycle N+1, valid/rdata in cycle N+2.
// Backpressure: a requester holds req until its gnt; one access in flight, issue interval 3 cycles.
module dmem_arbiter #(
    parameter int MEM_BYTES = dmem_pkg::MEM_BYTES,
    parameter int DATA_W    = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [31:0]       r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_valid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [31:0]       r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import dmem_pkg::*;

    state_t            state, state_nxt;
    logic              last;
    logic              win;
    logic              we_q;
    logic              err_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [DATA_W-1:0] rd_cap;
    logic [1:0]        pick;
    logic              legal;

    rr_arb2 u_arb (
        .req  ({r1_req, r0_req}),
        .last (last),
        .gnt  (pick)
    );

    assign legal    = addr_legal(addr_q, MEM_BYTES);
    assign rd_cap   = (legal && !we_q) ? mem_rdata : '0;
    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;

    always_comb begin
        state_nxt = state;
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        r0_err    = 1'b0;
        r1_err    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (|pick) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
                r0_gnt    = !win;
                r1_gnt    = win;
                // Illegal accesses never reach the memory; they only report err.
                if (legal) begin
                    mem_read  = !we_q;
                    mem_write = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                r0_valid  = !win;
                r1_valid  = win;
                r0_err    = !win && err_q;
                r1_err    = win && err_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |pick) begin
                win     <= pick[1];
                last    <= pick[1];
                we_q    <= pick[1] ? r1_we    : r0_we;
                addr_q  <= pick[1] ? r1_addr  : r0_addr;
                wdata_q <= pick[1] ? r1_wdata : r0_wdata;
            end
            if (state == ACCESS) begin
                err_q <= !legal;
                if (win) rdata1_q <= rd_cap;
                else     rdata0_q <= rd_cap;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Model tracks the next free issue edge, the round-robin winner and a reference byte memory.
module tb_dmem_arbiter;

    localparam int MB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r0_gnt, r0_valid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_valid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MB), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_valid(r0_valid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_valid(r1_valid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Physical memory seen by the DUT; cleared whenever reset is applied.
    logic [7:0] mem [MB];
    logic [4:0] mi;
    assign mi = mem_addr[4:0];
    assign mem_rdata = (mem_read && mem_addr <= MB - 4) ?
                       {mem[mi + 5'd3], mem[mi + 5'd2], mem[mi + 5'd1], mem[mi]} : 32'h5A5A_5A5A;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
        end else if (mem_write && mem_addr <= MB - 4) begin
            mem[mi]        <= mem_wdata[7:0];
            mem[mi + 5'd1] <= mem_wdata[15:8];
            mem[mi + 5'd2] <= mem_wdata[23:16];
            mem[mi + 5'd3] <= mem_wdata[31:24];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          edge_n = 0;
    int          free_edge = 0;
    int          m_last = 1;
    int          g_edge = -10;
    int          g_port = 0;
    logic        g_we;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic        g_err;
    logic [7:0]  ref_mem [MB];

    // Observations
    int          vcount [2] = '{0, 0};
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          gq_port [$];
    int          gq_edge [$];

    function automatic logic model_legal(input logic [31:0] a);
        longint unsigned ea;
        ea = a;
        return (ea % 4 == 0) && (ea + 4 <= MB);
    endfunction

    task automatic step();
        logic [1:0]  p_req;
        logic [1:0]  p_we;
        logic [31:0] p_addr [2];
        logic [31:0] p_wdata [2];
        logic        rsamp;
        logic        acc, rsp, ok;
        int          ia;
        p_req = {r1_req, r0_req};
        p_we  = {r1_we, r0_we};
        p_addr[0] = r0_addr;  p_addr[1] = r1_addr;
        p_wdata[0] = r0_wdata; p_wdata[1] = r1_wdata;
        rsamp = rst;
        @(posedge clk);
        edge_n++;
        if (rsamp) begin
            free_edge = edge_n + 1;
            m_last = 1;
            g_edge = -10;
            for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
        end else if (edge_n >= free_edge && p_req != 2'b00) begin
            if (p_req == 2'b11) g_port = (m_last == 1) ? 0 : 1;
            else                g_port = p_req[1] ? 1 : 0;
            m_last    = g_port;
            free_edge = edge_n + 3;
            g_edge    = edge_n;
            g_we      = p_we[g_port];
            g_addr    = p_addr[g_port];
            g_wdata   = p_wdata[g_port];
            g_err     = !model_legal(g_addr);
            g_rdata   = 32'h0;
            if (!g_err) begin
                ia = int'(g_addr[4:0]);
                if (g_we) begin
                    for (int b = 0; b < 4; b++) ref_mem[ia + b] = g_wdata[8*b +: 8];
                end else begin
                    for (int b = 0; b < 4; b++) g_rdata[8*b +: 8] = ref_mem[ia + b];
                end
            end
        end
        @(negedge clk);
        acc = (edge_n == g_edge);
        rsp = (edge_n == g_edge + 1);
        ok  = !g_err;
        check_val("r0_gnt", r0_gnt, acc && g_port == 0);
        check_val("r1_gnt", r1_gnt, acc && g_port == 1);
        check_val("mem_read", mem_read, acc && ok && !g_we);
        check_val("mem_write", mem_write, acc && ok && g_we);
        check_val("mem_addr", mem_addr, (acc && ok) ? g_addr : 32'h0);
        check_val("mem_wdata", mem_wdata, (acc && ok) ? g_wdata : 32'h0);
        check_val("r0_valid", r0_valid, rsp && g_port == 0);
        check_val("r1_valid", r1_valid, rsp && g_port == 1);
        check_val("r0_err", r0_err, rsp && g_port == 0 && g_err);
        check_val("r1_err", r1_err, rsp && g_port == 1 && g_err);
        if (rsp && g_port == 0) check_val("r0_rdata", r0_rdata, g_rdata);
        if (rsp && g_port == 1) check_val("r1_rdata", r1_rdata, g_rdata);
        if (r0_gnt) begin gq_port.push_back(0); gq_edge.push_back(edge_n); end
        if (r1_gnt) begin gq_port.push_back(1); gq_edge.push_back(edge_n); end
        if (r0_valid) begin vcount[0]++; last_rdata[0] = r0_rdata; last_err[0] = r0_err; end
        if (r1_valid) begin vcount[1]++; last_rdata[1] = r1_rdata; last_err[1] = r1_err; end
        if (acc) begin
            if (g_port == 0) r0_req = 1'b0;
            else             r1_req = 1'b0;
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
        else        begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    endtask

    task automatic run_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int v0;
        logic done;
        v0 = vcount[p];
        done = 1'b0;
        set_req(p, we, a, d);
        for (int i = 0; i < 12 && !done; i++) begin
            step();
            done = (vcount[p] != v0);
        end
        check_val("txn_done", done, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            step();
            idle = !r0_req && !r1_req;
        end
        check_val("drain", idle, 1'b1);
        for (int i = 0; i < 3; i++) step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 35));
            2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 7) * 4);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int v1;
        int n_raise;
        logic got_gnt;
        rst = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        do_reset(2);

        // Store then load at 20
        run_txn(0, 1'b1, 32'd20, 32'hDEAD_BEEF);
        check_val("st20_err", last_err[0], 1'b0);
        run_txn(0, 1'b0, 32'd20, 32'h0);
        check_val("ld20_data", last_rdata[0], 32'hDEAD_BEEF);

        // Both ports held: expect 0,1,0,1 with grants 3 edges apart
        do_reset(1);
        gq_port.delete(); gq_edge.delete();
        set_req(0, 1'b0, 32'd4, 32'h0);
        set_req(1, 1'b0, 32'd8, 32'h0);
        n_raise = 2;
        for (int i = 0; i < 40 && (r0_req || r1_req || n_raise < 4); i++) begin
            step();
            if (n_raise < 4 && !r0_req) begin set_req(0, 1'b0, 32'd12, 32'h0); n_raise++; end
            if (n_raise < 4 && !r1_req) begin set_req(1, 1'b0, 32'd16, 32'h0); n_raise++; end
        end
        check_val("rr_count", gq_port.size(), 4);
        for (int i = 0; i < 4 && i < gq_port.size(); i++) begin
            check_val("rr_order", gq_port[i], i % 2);
            if (i > 0) check_val("rr_gap", gq_edge[i] - gq_edge[i-1], 3);
        end
        drain(10);

        // Illegal addresses on port 1
        run_txn(1, 1'b0, 32'd22, 32'h0);
        check_val("mis_err", last_err[1], 1'b1);
        run_txn(1, 1'b0, 32'd32, 32'h0);
        check_val("oor_err", last_err[1], 1'b1);
        run_txn(1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        check_val("wrap_err", last_err[1], 1'b1);
        check_val("wrap_rdata", last_rdata[1], 32'h0);

        // Highest legal word
        run_txn(0, 1'b1, 32'd28, 32'hA5C3_0F96);
        run_txn(0, 1'b0, 32'd28, 32'h0);
        check_val("top_err", last_err[0], 1'b0);
        check_val("top_data", last_rdata[0], 32'hA5C3_0F96);

        // Reset during ACCESS of a port-1 store
        gq_port.delete(); gq_edge.delete();
        set_req(1, 1'b1, 32'd8, 32'h1234_5678);
        got_gnt = 1'b0;
        for (int i = 0; i < 8 && !got_gnt; i++) begin
            step();
            got_gnt = (gq_port.size() != 0);
        end
        check_val("rst_pre_gnt", got_gnt, 1'b1);
        v1 = vcount[1];
        do_reset(1);
        for (int i = 0; i < 4; i++) step();
        check_val("rst_no_valid", vcount[1] - v1, 0);
        gq_port.delete(); gq_edge.delete();
        set_req(0, 1'b0, 32'd0, 32'h0);
        set_req(1, 1'b0, 32'd4, 32'h0);
        drain(12);
        check_val("rst_first_port", (gq_port.size() > 0) ? gq_port[0] : 9, 0);

        // Idle scan
        for (int i = 0; i < 20; i++) step();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            step();
            rst = 1'b0;
            if (!r0_req && $urandom_range(0, 2) == 0)
                set_req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (!r1_req && $urandom_range(0, 2) == 0)
                set_req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
